alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter W, default 4, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) has a command.
REQ-005 SHALL have ports reqN_ready  output  1  command of requester N accepted this cycle.
REQ-006 SHALL have ports reqN_a, reqN_b  input  W  operands A and B of requester N.
REQ-007 SHALL have ports reqN_op  input  4  opcode of requester N (0000 add ... 1001 shift right).
REQ-008 SHALL have port rsp_valid  output  1  response available.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes the response.
REQ-010 SHALL have port rsp_id  output  1  index of the requester that owns the response.
REQ-011 SHALL have port rsp_result  output  W  result.
REQ-012 SHALL have port rsp_flags  output  4  {N,Z,C,V}.
REQ-013 SHALL have port rsp_err  output  1  illegal opcode or divide by zero.
REQ-014 SHALL have ports alu_a, alu_b_inv, alu_op  output  W/W/4  drive to the shared ALU; alu_b_inv is the bitwise complement of operand B.
REQ-015 SHALL have ports alu_result, alu_n, alu_z, alu_c, alu_v  input  W/1/1/1/1  combinational ALU outputs.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-017 IDLE: the granted requester is reqP if reqP_valid, where P is the priority pointer; otherwise the other requester if its valid is high; otherwise none.
REQ-018 reqN_ready SHALL be high only in IDLE, only for the granted requester; at most one ready is high per cycle.
REQ-019 On accept (valid&&ready): capture a, b, op and id into operand registers, set P to the other requester, go to EXEC.
REQ-020 alu_a, alu_b_inv and alu_op SHALL come from the operand registers only, so they are stable in every state.
REQ-021 EXEC (exactly one cycle): capture alu_result and {alu_n,alu_z,alu_c,alu_v} into response registers, with rsp_err=0, then go to RESP.
REQ-022 In EXEC, if op>=4'b1010, or if op is 0011/0100 with B==0: rsp_result=0, rsp_flags=0 and rsp_err=1; the ALU outputs are ignored.
REQ-023 RESP: rsp_valid=1, and rsp_id/result/flags/err are held stable until rsp_ready=1; on that edge go to IDLE.
REQ-024 Latency SHALL be fixed: if a command is accepted at edge E, rsp_valid is high from the cycle after edge E+1.
REQ-025 SHALL accept no new command while in EXEC or RESP; minimum issue interval is 3 cycles.
REQ-026 With both requesters continuously valid and rsp_ready=1, grants SHALL alternate 0,1,0,1...
REQ-027 A requester that drops valid before ready SHALL not be granted; nothing is latched for it.

Reset
REQ-028 When rst=1 at a clock edge: state=IDLE and P=0.
REQ-029 On reset, operand registers SHALL clear to 0, so alu_a=0, alu_b_inv=all ones and alu_op=0.
REQ-030 On reset, rsp_valid=0 and rsp_id/result/flags/err=0; reqN_ready follows REQ-018 from the next cycle.
REQ-031 Reset in EXEC or RESP SHALL discard the in-flight command; no response is produced for it.
REQ-032 rst SHALL override all other inputs in the same cycle.

Verification
REQ-033 Reset, no valids: rsp_valid=0, req0_ready=req1_ready=0, alu_b_inv=4'b1111.
REQ-034 req0: a=7, b=9, op=0000: accepted at edge E; rsp_valid from after E+1 with rsp_id=0, result=0, flags N=0 Z=1 C=1 V=0, err=0.
REQ-035 Both valid right after reset, with req0 op=0101 a=12 b=10 and req1 op=0110 a=3 b=4: first response id=0 result=8; second id=1 result=7; third grant goes to req0.
REQ-036 req1: op=0011, a=9, b=0: rsp_err=1, result=0, flags=0. Then op=1111: rsp_err=1.
REQ-037 rsp_ready held low for 5 cycles in RESP: response fields stay constant and both reqN_ready stay 0; response completes on the first rsp_ready=1 cycle.
REQ-038 rst pulsed during EXEC of a req1 command: no rsp_valid follows; with both valid afterwards, req0 is granted first.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bus between two requesters, the arbiter and its consumer
interface alu_arbiter_if #(
  parameter int W = 4
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [3:0]   req0_op;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [3:0]   req1_op;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic         rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter in front of a shared combinational ALU
module alu_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b_inv,
  output logic [3:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_c,
  input  logic         alu_v
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_q, state_d;
  logic         prio_q, prio_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [3:0]   op_q, op_d;
  logic         id_q, id_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]   rsp_flags_q, rsp_flags_d;
  logic         rsp_err_q, rsp_err_d;

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic         gnt_valid;
  logic         gnt_id;
  logic         op_err;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  // Undefined opcodes and division/modulo by zero bypass the ALU result.
  assign op_err = (op_q >= 4'b1010) ||
                  (((op_q == 4'b0011) || (op_q == 4'b0100)) && (b_q == '0));

  // Priority pick: the pointed-to requester first, the other one as fallback.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = prio_q;
    if (req_valid[prio_q]) begin
      gnt_valid = 1'b1;
      gnt_id    = prio_q;
    end else if (req_valid[~prio_q]) begin
      gnt_valid = 1'b1;
      gnt_id    = ~prio_q;
    end
  end

  // Next-state, operand capture and response capture.
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          // Ready only goes to a valid requester, so a grant is an accept.
          req_ready[gnt_id] = 1'b1;
          a_d     = gnt_id ? bus.req1_a  : bus.req0_a;
          b_d     = gnt_id ? bus.req1_b  : bus.req0_b;
          op_d    = gnt_id ? bus.req1_op : bus.req0_op;
          id_d    = gnt_id;
          prio_d  = ~gnt_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_id_d = id_q;
        if (op_err) begin
          rsp_result_d = '0;
          rsp_flags_d  = 4'b0000;
          rsp_err_d    = 1'b1;
        end else begin
          rsp_result_d = alu_result;
          rsp_flags_d  = {alu_n, alu_z, alu_c, alu_v};
          rsp_err_d    = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 4'b0000;
      id_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'b0000;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_err    = rsp_err_q;

  assign alu_a     = a_q;
  assign alu_b_inv = ~b_q;
  assign alu_op    = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  logic       clk;
  logic       rst;
  logic [3:0] alu_a, alu_b_inv, alu_op, alu_result;
  logic       alu_n, alu_z, alu_c, alu_v;
  logic [3:0] alu_b;
  int         total;
  int         fails;

  alu_arbiter_if #(.W(4)) bus ();

  alu_arbiter #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b_inv (alu_b_inv),
    .alu_op    (alu_op),
    .alu_result(alu_result),
    .alu_n     (alu_n),
    .alu_z     (alu_z),
    .alu_c     (alu_c),
    .alu_v     (alu_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared ALU; unsupported opcodes drive a distinctive junk value.
  assign alu_b = ~alu_b_inv;
  always_comb begin
    alu_result = 4'hA;
    alu_c      = 1'b1;
    alu_v      = 1'b1;
    case (alu_op)
      4'b0000: begin
        {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[3] == alu_b[3]) && (alu_result[3] != alu_a[3]);
      end
      4'b0101: begin alu_result = alu_a & alu_b; alu_c = 1'b0; alu_v = 1'b0; end
      4'b0110: begin alu_result = alu_a | alu_b; alu_c = 1'b0; alu_v = 1'b0; end
      default: ;
    endcase
    alu_n = (alu_op > 4'b0110) ? 1'b1 : alu_result[3];
    alu_z = (alu_op > 4'b0110) ? 1'b1 : (alu_result == 4'h0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] op,
                         input logic [3:0] a, input logic [3:0] b);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  initial begin
    total = 0;
    fails = 0;
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b0, 4'h0, 4'h0, 4'h0);
    set_req(1, 1'b0, 4'h0, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Reset state with no requests
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_b_inv", alu_b_inv, 4'b1111);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);

    // Single add 7+9: fixed two-edge latency, Z and C set
    @(negedge clk);
    set_req(0, 1'b1, 4'b0000, 4'd7, 4'd9);
    #1 chk("add_ready0", bus.req0_ready, 1);
    chk("add_ready1", bus.req1_ready, 0);
    @(posedge clk);
    #1 bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("add_exec_valid", bus.rsp_valid, 0);
    chk("add_exec_ready0", bus.req0_ready, 0);
    chk("add_alu_a", alu_a, 7);
    chk("add_alu_b_inv", alu_b_inv, 4'b0110);
    @(negedge clk);
    chk("add_rsp_valid", bus.rsp_valid, 1);
    chk("add_rsp_id", bus.rsp_id, 0);
    chk("add_rsp_result", bus.rsp_result, 0);
    chk("add_rsp_flags", bus.rsp_flags, 4'b0110);
    chk("add_rsp_err", bus.rsp_err, 0);
    @(negedge clk);
    chk("add_rsp_done", bus.rsp_valid, 0);

    // Both requesters valid from reset: grants alternate 0,1,0
    rst = 1'b1;
    set_req(0, 1'b1, 4'b0101, 4'd12, 4'd10);
    set_req(1, 1'b1, 4'b0110, 4'd3, 4'd4);
    @(negedge clk) rst = 1'b0;
    #1 chk("rr_g0_ready0", bus.req0_ready, 1);
    chk("rr_g0_ready1", bus.req1_ready, 0);
    repeat (2) @(negedge clk);
    chk("rr_r0_valid", bus.rsp_valid, 1);
    chk("rr_r0_id", bus.rsp_id, 0);
    chk("rr_r0_result", bus.rsp_result, 8);
    chk("rr_r0_flags", bus.rsp_flags, 4'b1000);
    @(negedge clk);
    chk("rr_g1_ready1", bus.req1_ready, 1);
    chk("rr_g1_ready0", bus.req0_ready, 0);
    repeat (2) @(negedge clk);
    chk("rr_r1_valid", bus.rsp_valid, 1);
    chk("rr_r1_id", bus.rsp_id, 1);
    chk("rr_r1_result", bus.rsp_result, 7);
    chk("rr_r1_flags", bus.rsp_flags, 4'b0000);
    @(negedge clk);
    chk("rr_g2_ready0", bus.req0_ready, 1);
    chk("rr_g2_ready1", bus.req1_ready, 0);

    // Drop both valids before the edge: nothing accepted
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("drop_no_rsp", bus.rsp_valid, 0);

    // Divide by zero from req1, then illegal opcode
    set_req(1, 1'b1, 4'b0011, 4'd9, 4'd0);
    #1 chk("dz_ready1", bus.req1_ready, 1);
    chk("dz_ready0", bus.req0_ready, 0);
    @(negedge clk);
    bus.req1_op = 4'b1111;
    @(negedge clk);
    chk("dz_valid", bus.rsp_valid, 1);
    chk("dz_id", bus.rsp_id, 1);
    chk("dz_err", bus.rsp_err, 1);
    chk("dz_result", bus.rsp_result, 0);
    chk("dz_flags", bus.rsp_flags, 0);
    @(negedge clk);
    chk("ill_ready1", bus.req1_ready, 1);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("ill_valid", bus.rsp_valid, 1);
    chk("ill_err", bus.rsp_err, 1);
    chk("ill_result", bus.rsp_result, 0);
    chk("ill_flags", bus.rsp_flags, 0);
    @(negedge clk);

    // Backpressure: rsp_ready low for five RESP cycles
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 4'b0110, 4'd5, 4'd2);
    set_req(1, 1'b1, 4'b0000, 4'd1, 4'd1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_id", bus.rsp_id, 0);
      chk("bp_result", bus.rsp_result, 7);
      chk("bp_flags", bus.rsp_flags, 0);
      chk("bp_err", bus.rsp_err, 0);
      chk("bp_readies", {bus.req1_ready, bus.req0_ready}, 2'b00);
      @(negedge clk);
    end
    chk("bp_still_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", bus.rsp_valid, 0);
    chk("bp_next_ready1", bus.req1_ready, 1);
    chk("bp_next_ready0", bus.req0_ready, 0);

    // Reset during EXEC of the req1 command: response discarded, pointer back to 0
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    #1 chk("rx_alu_a", alu_a, 0);
    chk("rx_b_inv", alu_b_inv, 4'b1111);
    chk("rx_valid0", bus.rsp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rx_no_rsp", bus.rsp_valid, 0);
    end
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1 chk("rx_ready0", bus.req0_ready, 1);
    chk("rx_ready1", bus.req1_ready, 0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
